// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and FSM state types for the sequential ALU
`timescale 1ns/1ps
package alu_pkg;

  localparam int ALUOP_W = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    NOTB = 3'b011,
    OR   = 3'b100,
    XOR  = 3'b101,
    SHL  = 3'b110,
    MUL  = 3'b111
  } alu_op_t;

  // State names carry an ST_ prefix so they do not collide with the MUL opcode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } fsm_state_t;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational ALU for all single-cycle operations
`timescale 1ns/1ps
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Result and overflow per opcode; MUL is handled by the sequential multiplier.
  always_comb begin
    result = '0;
    v      = 1'b0;
    case (op)
      ADD: begin
        result = sum;
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        result = diff;
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      AND:     result = a & b;
      NOTB:    result = ~b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      SHL:     result = a << b[SHW-1:0];
      default: result = '0;
    endcase
  end

  assign z = (result == '0);
  assign n = result[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshakes and shift-add multiplier
`timescale 1ns/1ps
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   Ain,
  input  logic [WIDTH-1:0]   Bin,
  input  logic [ALUOP_W-1:0] ALUop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               Z,
  output logic               N,
  output logic               V
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_op_t          op;
  fsm_state_t       state;
  logic             rdy_en;
  logic [WIDTH-1:0] mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             take;
  logic [WIDTH-1:0] c_res;
  logic             c_z;
  logic             c_n;
  logic             c_v;

  assign op = alu_op_t'(ALUop);

  // rdy_en keeps in_ready low during reset and for the first cycle after release.
  assign in_ready = rdy_en && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_alu_comb (
    .a      (Ain),
    .b      (Bin),
    .op     (op),
    .result (c_res),
    .z      (c_z),
    .n      (c_n),
    .v      (c_v)
  );

  // Control FSM and shift-add multiplier: one multiplier bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept && op == MUL) begin
            mcand  <= {{WIDTH{1'b0}}, Ain};
            mplier <= Bin;
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: loaded by a single-cycle accept or by the multiplier finishing,
  // otherwise held until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept && op != MUL) begin
      out       <= c_res;
      Z         <= c_z;
      N         <= c_n;
      V         <= c_v;
      out_valid <= 1'b1;
    end else if (state == ST_DONE) begin
      out       <= acc[WIDTH-1:0];
      Z         <= (acc[WIDTH-1:0] == '0);
      N         <= acc[WIDTH-1];
      V         <= |acc[2*WIDTH-1:WIDTH];
      out_valid <= 1'b1;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath 16-bit ALU, which is combinational and supports add/sub/and/not-B with a Z flag.
- Adds OR, XOR, shifts and a multi-cycle unsigned multiply, plus N and V status flags.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the register file and the writeback stage of a pipelined datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), number of B bits used as the shift amount (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- Ain  input  WIDTH  operand A.
- Bin  input  WIDTH  operand B.
- ALUop  input  3  operation code (alu_pkg::alu_op_t).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result.
- Z  output  1  result == 0.
- N  output  1  result MSB.
- V  output  1  overflow (per-op rule below).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. During reset, out=0, Z=0, N=0, V=0, out_valid=0, in_ready=0, FSM=IDLE.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - out, Z, N and V hold stable while out_valid=1 && out_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- Opcodes:
  - ADD=000: A+B, mod 2^WIDTH.
  - SUB=001: A-B.
  - AND=010.
  - NOTB=011: ~B, A ignored.
  - OR=100.
  - XOR=101.
  - SHL=110: A << B[SHW-1:0], zero fill.
  - MUL=111: unsigned A*B, low WIDTH bits to out.
- V rules:
  - ADD/SUB: signed two's-complement overflow, i.e. operand signs as required by the op and result sign differs.
  - MUL: V=1 iff the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - All others: V=0.
- Latency:
  - Single-cycle ops: result registered at the accepting edge, out_valid=1 the following cycle (latency 1).
  - MUL: latency WIDTH+1 cycles from accept to out_valid.
- FSM states:
  - IDLE: accept ops. A non-MUL op loads the output register directly. A MUL op latches A, B, clears the product accumulator and count, then goes to MUL.
  - MUL: shift-add one multiplier bit per cycle, WIDTH iterations; in_ready=0. When count==WIDTH-1, go to DONE.
  - DONE: load out/flags from the accumulator, set out_valid, return to IDLE. No accept in DONE.
- Boundary conditions:
  - Result register full and out_ready=0: in_ready=0, no op is lost.
  - Output taken and new op accepted in the same cycle: both happen, and the new result replaces the old one at that edge.
  - in_valid dropped while in_ready=0: nothing is captured.
  - Operands changing during MUL: no effect, because they are latched.
  - Shift amount >= WIDTH: cannot occur, since only SHW bits are used.
  - Reset asserted mid-MUL: result discarded, all state returns to reset values immediately.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t {ADD, SUB, AND, NOTB, OR, XOR, SHL, MUL}.
  - typedef enum of FSM states {IDLE, MUL, DONE}.
  - Constant ALUOP_W=3.
- alu_comb sub-module: the combinational ALU computing result, Z, N and V for all single-cycle ops at parameter WIDTH. It is reused in the datapath and checked standalone.
- alu_seq holds the handshake, output register, multiplier FSM and accumulator.

Test Plan (WIDTH=16):
- Reset mid-MUL: accept 0x00FF*0x0101, assert reset at cycle 5 → out_valid=0 and out=0 immediately. After release, in_ready=1 on the next cycle and a new ADD 1+2 returns 3.
- ADD with overflow: 0x7FFF+0x0001 → out=0x8000, N=1, V=1, Z=0, 1 cycle later. SUB 5-5 → out=0, Z=1, V=0.
- Back-to-back: out_ready held 1, issue AND 0xFFFF&0x0F0F, then XOR 0xAAAA^0xFFFF, then SHL 0x0001<<15 on consecutive cycles → 0x0F0F, 0x5555, 0x8000 (N=1) on three consecutive cycles, in_ready stays 1.
- Backpressure: out_ready=0 after NOTB B=0 → out=0xFFFF held, in_ready=0 while in_valid=1 with OR 1|2 pending. Raise out_ready → 0xFFFF consumed, OR accepted the same cycle, out=0x0003 next cycle.
- MUL latency/overflow: 300*300 → out=0x5F90 (90000 mod 65536), V=1, out_valid exactly 17 cycles after accept, in_ready=0 throughout. 12*11 → out=132, V=0.
- MUL with zero operand: 0*0xFFFF → out=0, Z=1, V=0.
